// File: rtl/avalon_st_arb_pkg.sv
// Shared types and the rotate-priority search for the Avalon-ST arbiter.
// Optional channel tagging: AVALON_ST_ARB_CHANNEL_EN.
package avalon_st_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BURST} arb_state_t;

  localparam int unsigned MAX_CH = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of valid searched from ptr+1 upward, wrapping at n.
  function automatic pick_t rr_pick(
    input logic [MAX_CH-1:0] valid,
    input logic [3:0]        ptr,
    input int unsigned       n
  );
    pick_t       r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      if (k <= n && !r.found) begin
        c = (ptr + k) % n;
        if (valid[c]) begin
          r.found = 1'b1;
          r.idx   = 4'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_st_rr_pick.sv
// Combinational rotate-priority encoder, NUM_CH wide.
// Lowest index strictly after ptr wins, wrapping modulo NUM_CH.
import avalon_st_arb_pkg::*;

module avalon_st_rr_pick #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [MAX_CH-1:0] v_ext;
  pick_t             p;

  always_comb begin
    v_ext               = '0;
    v_ext[NUM_CH-1:0]   = valid;
    p                   = rr_pick(v_ext, 4'(ptr), NUM_CH);
    found               = p.found;
    idx                 = CH_W'(p.idx);
  end

endmodule

// File: rtl/avalon_st_rr_arbiter.sv
// Round-robin burst arbiter sharing one registered Avalon-ST source.
// Define AVALON_ST_ARB_CHANNEL_EN to add the source_channel tag.
import avalon_st_arb_pkg::*;

module avalon_st_rr_arbiter #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] sink_data,
  input  logic [NUM_CH-1:0]            sink_valid,
  input  logic [NUM_CH-1:0]            sink_error,
  output logic [NUM_CH-1:0]            sink_ready,
  output logic [DATA_WIDTH-1:0]        source_data,
  output logic                         source_valid,
  output logic                         source_error,
  input  logic                         source_ready
`ifdef AVALON_ST_ARB_CHANNEL_EN
  ,
  output logic [CH_W-1:0]              source_channel
`endif
);

  localparam logic [7:0]      MB   = 8'(MAX_BURST);
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  arb_state_t            state_q, state_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic [CH_W-1:0]       owner_q, owner_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef AVALON_ST_ARB_CHANNEL_EN
  logic [CH_W-1:0]       chan_q, chan_d;
`endif

  logic                  free, burst_end, keep, xfer;
  logic                  pick_found;
  logic [CH_W-1:0]       pick_ptr, pick_idx, grant;

  assign free      = !valid_q || source_ready;
  assign burst_end = (state_q == ST_BURST) &&
                     (!sink_valid[owner_q] || cnt_q >= MB);
  assign keep      = (state_q == ST_BURST) && !burst_end;
  // An ending burst re-arbitrates in the same cycle from owner+1.
  assign pick_ptr  = burst_end ? owner_q : ptr_q;

  avalon_st_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .valid (sink_valid),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    grant      = keep ? owner_q : pick_idx;
    xfer       = free && !reset && (keep || pick_found);
    sink_ready = '0;
    if (xfer) sink_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (burst_end) begin
      state_d = ST_IDLE;
      ptr_d   = owner_q;
      cnt_d   = '0;
    end
    if (xfer) begin
      if (keep) begin
        cnt_d = (cnt_q < MB) ? cnt_q + 8'd1 : cnt_q;
      end else if (MAX_BURST == 1) begin
        ptr_d = grant;
      end else begin
        state_d = ST_BURST;
        owner_d = grant;
        cnt_d   = 8'd1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
`ifdef AVALON_ST_ARB_CHANNEL_EN
    chan_d  = chan_q;
`endif
    if (free) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = sink_data[grant*DATA_WIDTH +: DATA_WIDTH];
        err_d  = sink_error[grant];
`ifdef AVALON_ST_ARB_CHANNEL_EN
        chan_d = grant;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= LAST;
      owner_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
`ifdef AVALON_ST_ARB_CHANNEL_EN
      chan_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
`ifdef AVALON_ST_ARB_CHANNEL_EN
      chan_q  <= chan_d;
`endif
    end
  end

  assign source_valid = valid_q;
  assign source_error = err_q;
  assign source_data  = data_q;
`ifdef AVALON_ST_ARB_CHANNEL_EN
  assign source_channel = chan_q;
`endif

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Randomized and directed bench for avalon_st_rr_arbiter.
// Reference model: last-owner pointer, run length, modulo search.
module tb_avalon_st_rr_arbiter;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(NC);

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] sink_data;
  logic [NC-1:0]    sink_valid, sink_error, sink_ready;
  logic [DW-1:0]    source_data;
  logic             source_valid, source_error, source_ready;
`ifdef AVALON_ST_ARB_CHANNEL_EN
  logic [CW-1:0]    source_channel;
`endif

  always #5 clk = ~clk;

  avalon_st_rr_arbiter #(
    .NUM_CH     (NC),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sink_data      (sink_data),
    .sink_valid     (sink_valid),
    .sink_error     (sink_error),
    .sink_ready     (sink_ready),
    .source_data    (source_data),
    .source_valid   (source_valid),
    .source_error   (source_error),
    .source_ready   (source_ready)
`ifdef AVALON_ST_ARB_CHANNEL_EN
    ,
    .source_channel (source_channel)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Producers: a presented beat stays valid and stable until accepted.
  logic [NC-1:0] hold;
  logic [DW-1:0] cur_d [NC];
  logic          cur_e [NC];
  int            mode;
  logic [DW-1:0] cust;
  logic [NC-1:0] err_mask;

  // Reference model state.
  logic          e_valid, e_err, e_rst;
  logic [DW-1:0] e_data;
  int            e_ch;
  int            last, run;
  bit            active;
  int            accepted, delivered, discarded;
  logic [8:0]    outq [$];

  function automatic logic [8:0] qat(input int i);
    return (i < outq.size()) ? outq[i] : 9'bx;
  endfunction

  task automatic step(input logic [NC-1:0] offer, input logic rdy,
                      input logic rst);
    int            g;
    int            c2;
    bit            free;
    logic [NC-1:0] exp_rdy;
    @(negedge clk);
    chk("src_valid", 32'(source_valid), 32'(e_valid));
    if (e_valid || e_rst) begin
      chk("src_data", 32'(source_data), 32'(e_data));
      chk("src_error", 32'(source_error), 32'(e_err));
`ifdef AVALON_ST_ARB_CHANNEL_EN
      chk("src_chan", 32'(source_channel), 32'(e_ch));
`endif
    end
    for (int c = 0; c < NC; c++) begin
      if (!hold[c] && offer[c]) begin
        hold[c]  = 1'b1;
        cur_d[c] = (mode == 0) ? 8'($urandom) :
                   (mode == 1) ? 8'(8'h10 + c) : cust;
        cur_e[c] = (mode == 0) ? ($urandom % 8 == 0) : err_mask[c];
      end
      sink_valid[c]         = hold[c];
      sink_data[c*DW +: DW] = cur_d[c];
      sink_error[c]         = cur_e[c];
    end
    source_ready = rdy;
    reset        = rst;
    if (source_valid && rdy) outq.push_back({source_error, source_data});
    if (e_valid && rdy) delivered++;
    else if (e_valid && rst) discarded++;
    #1;
    g = -1;
    if (rst) begin
      e_valid = 1'b0; e_err = 1'b0; e_data = '0; e_ch = 0;
      last = NC - 1; run = 0; active = 0; e_rst = 1'b1;
    end else begin
      e_rst = 1'b0;
      free  = !e_valid || rdy;
      if (active && (!sink_valid[last] || run >= MB)) active = 0;
      if (free) begin
        if (active) g = last;
        else
          for (int k = 1; k <= NC; k++) begin
            c2 = (last + k) % NC;
            if (g < 0 && sink_valid[c2]) g = c2;
          end
      end
      if (g >= 0) begin
        if (active) run++;
        else begin last = g; run = 1; active = 1; end
        e_valid = 1'b1; e_data = cur_d[g]; e_err = cur_e[g]; e_ch = g;
        hold[g] = 1'b0;
        accepted++;
      end else if (free) begin
        e_valid = 1'b0;
      end
    end
    exp_rdy = (g >= 0) ? NC'(1) << g : '0;
    chk("sink_ready", 32'(sink_ready), 32'(exp_rdy));
  endtask

  task automatic flush_reset();
    repeat (3 * NC * MB) step('0, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1, 1'b1);
    outq.delete();
  endtask

  initial begin
    reset = 1'b1; sink_valid = '0; sink_data = '0; sink_error = '0;
    source_ready = 1'b0; hold = '0; mode = 0; cust = '0; err_mask = '0;
    e_valid = 1'b0; e_err = 1'b0; e_data = '0; e_ch = 0; e_rst = 1'b1;
    last = NC - 1; run = 0; active = 0;
    accepted = 0; delivered = 0; discarded = 0;
    for (int c = 0; c < NC; c++) begin cur_d[c] = '0; cur_e[c] = 1'b0; end
    @(posedge clk);
    repeat (5) step('0, 1'b0, 1'b1);

    // single beat from ch1
    mode = 2; cust = 8'h01;
    step(4'b0010, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1, 1'b0);
    chk("t1_beat", 32'(qat(0)), 32'h001);

    // all channels, full bursts in rotation
    flush_reset();
    mode = 1;
    repeat (21) step(4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      chk("t2_seq", 32'(qat(i)), 32'(8'h10 + (i / 4) % 4));

    // lone requester re-granted with no bubble
    flush_reset();
    repeat (14) step(4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) chk("t3_seq", 32'(qat(i)), 32'h012);

    // stall mid-burst on ch0
    flush_reset();
    repeat (2) step(4'b0001, 1'b1, 1'b0);
    repeat (10) step(4'b0001, 1'b0, 1'b0);
    repeat (6) step(4'b0001, 1'b1, 1'b0);
    chk("t4_cnt", 32'(outq.size()), 32'd7);

    // ch3 drops after two beats, waiting ch1 takes over
    flush_reset();
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);
    chk("t5_b0", 32'(qat(0)), 32'h013);
    chk("t5_b1", 32'(qat(1)), 32'h013);
    chk("t5_b2", 32'(qat(2)), 32'h011);

    // reset with a held output beat
    flush_reset();
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    outq.delete();
    repeat (4) step(4'hF, 1'b1, 1'b0);
    chk("t6_first", 32'(qat(0)), 32'h010);

    // error flag travels with the beat
    flush_reset();
    mode = 2; cust = 8'h2A; err_mask = 4'b0100;
    step(4'b0100, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1, 1'b0);
    chk("t7_err", 32'(qat(0)), 32'h12A);

    // random traffic, stalls and occasional resets
    mode = 0;
    for (int i = 0; i < 3000; i++)
      step(NC'($urandom), ($urandom % 4) != 0, ($urandom % 300) == 0);
    repeat (40) step('0, 1'b1, 1'b0);
    chk("beats", 32'(delivered), 32'(accepted - discarded));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
